// File: rtl/iir_sched_pkg.sv
// Shared types and helpers for the time-multiplexed biquad engine iir_sched.
// The saturate helper is only used when IIR_SCHED_SAT_EN is defined.
package iir_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_MAC4,
    ST_SHIFT,
    ST_OUT
  } state_t;

  localparam int NTAPS = 5;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int accWidth(input int dataW, input int coefW);
    return dataW + coefW + 3;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int dataW);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dataW - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dataW - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/iir_sched_rr_arbiter.sv
// Combinational round-robin picker: first pending channel after the last grant.
module rr_arbiter
  import iir_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         i_pending,
  input  logic [$clog2(NCH)-1:0] i_lastGrant,
  output logic [$clog2(NCH)-1:0] o_grant,
  output logic                   o_valid
);

  localparam int CH_W = $clog2(NCH);

  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = CH_W'((int'(i_lastGrant) + i) % NCH);
      if (!o_valid && i_pending[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/iir_sched.sv
// Shared-MAC biquad IIR engine for NCH channels with host-loaded coefficients.
// Define IIR_SCHED_SAT_EN to saturate y instead of wrapping it to DATA_W bits.
module iir_sched
  import iir_sched_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 9
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic [NCH*DATA_W-1:0]      in_sample,
  input  logic [NCH-1:0]             in_tick,
  input  logic                       cfg_we,
  input  logic [$clog2(NCH)+2:0]     cfg_addr,
  input  logic signed [COEF_W-1:0]   cfg_data,
  output logic signed [DATA_W-1:0]   out_sample,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic                       out_tick,
  output logic                       busy,
  output logic [NCH-1:0]             overrun
);

  localparam int CH_W   = $clog2(NCH);
  localparam int ACC_W  = accWidth(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [COEF_W-1:0] r_coef [NCH][NTAPS];
  logic signed [DATA_W-1:0] r_hold [NCH];
  logic signed [DATA_W-1:0] r_x1   [NCH];
  logic signed [DATA_W-1:0] r_x2   [NCH];
  logic signed [DATA_W-1:0] r_y1   [NCH];
  logic signed [DATA_W-1:0] r_y2   [NCH];
  logic [NCH-1:0]           r_pending;
  logic [NCH-1:0]           r_overrun;

  state_t r_state;
  state_t w_nextState;

  logic [CH_W-1:0] r_grant;
  logic [CH_W-1:0] r_lastGrant;
  logic [CH_W-1:0] w_grant;
  logic            w_grantValid;

  logic signed [DATA_W-1:0] r_wx0, r_wx1, r_wx2, r_wy1, r_wy2;
  logic signed [COEF_W-1:0] r_wc [NTAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] r_outSample;
  logic [CH_W-1:0]          r_outCh;
  logic                     r_outTick;

  logic w_load, w_mac, w_shift, w_out;
  logic [NCH-1:0]           w_clear;
  logic [CH_W-1:0]          w_cfgCh;
  logic [2:0]               w_cfgTap;
  logic signed [DATA_W-1:0] w_opX;
  logic signed [COEF_W-1:0] w_opC;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [DATA_W-1:0] w_yNext;

  assign w_cfgCh  = cfg_addr[CH_W+2:3];
  assign w_cfgTap = cfg_addr[2:0];

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_pending   (r_pending),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant),
    .o_valid     (w_grantValid)
  );

  always_ff @(posedge CLK) begin
    if (!RSTb) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:  if (|r_pending) w_nextState = ST_LOAD;
      ST_LOAD:  w_nextState = w_grantValid ? ST_MAC0 : ST_IDLE;
      ST_MAC0:  w_nextState = ST_MAC1;
      ST_MAC1:  w_nextState = ST_MAC2;
      ST_MAC2:  w_nextState = ST_MAC3;
      ST_MAC3:  w_nextState = ST_MAC4;
      ST_MAC4:  w_nextState = ST_SHIFT;
      ST_SHIFT: w_nextState = ST_OUT;
      ST_OUT:   w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_mac   = 1'b0;
    w_shift = 1'b0;
    w_out   = 1'b0;
    busy    = (r_state != ST_IDLE);
    unique case (r_state)
      ST_LOAD:  w_load = w_grantValid;
      ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3, ST_MAC4: w_mac = 1'b1;
      ST_SHIFT: w_shift = 1'b1;
      ST_OUT:   w_out = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    w_clear = '0;
    for (int c = 0; c < NCH; c++)
      w_clear[c] = w_load && (w_grant == CH_W'(c));
  end

  // A tick landing on the LOAD edge of its own channel refills the slot just consumed.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int c = 0; c < NCH; c++) r_hold[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (in_tick[c]) begin
          r_hold[c]    <= in_sample[c*DATA_W +: DATA_W];
          r_pending[c] <= 1'b1;
          if (r_pending[c] && !w_clear[c]) r_overrun[c] <= 1'b1;
        end else if (w_clear[c]) begin
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAPS; t++) r_coef[c][t] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAPS; t++)
          if (cfg_we && w_cfgCh == CH_W'(c) && w_cfgTap == 3'(t))
            r_coef[c][t] <= cfg_data;
    end
  end

  always_comb begin
    w_opX = '0;
    w_opC = '0;
    unique case (r_state)
      ST_MAC0: begin w_opX = r_wx0; w_opC = r_wc[B0]; end
      ST_MAC1: begin w_opX = r_wx1; w_opC = r_wc[B1]; end
      ST_MAC2: begin w_opX = r_wx2; w_opC = r_wc[B2]; end
      ST_MAC3: begin w_opX = r_wy1; w_opC = r_wc[A1]; end
      ST_MAC4: begin w_opX = r_wy2; w_opC = r_wc[A2]; end
      default: ;
    endcase
  end

  assign w_prod    = PROD_W'(w_opX) * PROD_W'(w_opC);
  assign w_shifted = r_acc >>> COEF_FRAC;

`ifdef IIR_SCHED_SAT_EN
  assign w_yNext = DATA_W'(saturate(64'(w_shifted), DATA_W));
`else
  assign w_yNext = DATA_W'(w_shifted);
`endif

  // Working copies decouple the running computation from host coefficient writes.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_grant     <= '0;
      r_lastGrant <= CH_W'(NCH - 1);
      r_wx0       <= '0;
      r_wx1       <= '0;
      r_wx2       <= '0;
      r_wy1       <= '0;
      r_wy2       <= '0;
      for (int t = 0; t < NTAPS; t++) r_wc[t] <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_outSample <= '0;
      r_outCh     <= '0;
      r_outTick   <= 1'b0;
    end else begin
      r_outTick <= 1'b0;
      if (w_load) begin
        r_grant     <= w_grant;
        r_lastGrant <= w_grant;
        r_wx0       <= r_hold[w_grant];
        r_wx1       <= r_x1[w_grant];
        r_wx2       <= r_x2[w_grant];
        r_wy1       <= r_y1[w_grant];
        r_wy2       <= r_y2[w_grant];
        for (int t = 0; t < NTAPS; t++) r_wc[t] <= r_coef[w_grant][t];
        r_acc       <= '0;
      end
      if (w_mac)   r_acc <= r_acc + ACC_W'(w_prod);
      if (w_shift) r_y   <= w_yNext;
      if (w_out) begin
        r_outTick   <= 1'b1;
        r_outSample <= r_y;
        r_outCh     <= r_grant;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int c = 0; c < NCH; c++) begin
        r_x1[c] <= '0;
        r_x2[c] <= '0;
        r_y1[c] <= '0;
        r_y2[c] <= '0;
      end
    end else if (w_out) begin
      r_x2[r_grant] <= r_wx1;
      r_x1[r_grant] <= r_wx0;
      r_y2[r_grant] <= r_wy1;
      r_y1[r_grant] <= r_y;
    end
  end

  assign out_sample = r_outSample;
  assign out_ch     = r_outCh;
  assign out_tick   = r_outTick;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_iir_sched.sv
// Bench for iir_sched: directed scenarios plus random bursts scored against a
// behavioural biquad / round-robin model; follows IIR_SCHED_SAT_EN like the RTL.
`timescale 1ns/1ps
module tb_iir_sched;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 9;
  localparam int CHW  = 2;

  logic                  CLK;
  logic                  RSTb;
  logic [NCH*DW-1:0]     in_sample;
  logic [NCH-1:0]        in_tick;
  logic                  cfg_we;
  logic [CHW+2:0]        cfg_addr;
  logic signed [CW-1:0]  cfg_data;
  logic signed [DW-1:0]  out_sample;
  logic [CHW-1:0]        out_ch;
  logic                  out_tick;
  logic                  busy;
  logic [NCH-1:0]        overrun;

  iir_sched #(.NCH(NCH), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(FRAC)) dut (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .in_sample  (in_sample),
    .in_tick    (in_tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .out_sample (out_sample),
    .out_ch     (out_ch),
    .out_tick   (out_tick),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int edgeCnt = 0;
  always @(posedge CLK) edgeCnt <= edgeCnt + 1;

  int     obsCh[$];
  longint obsY[$];
  int     obsEdge[$];
  int     doubleTicks = 0;
  logic   prevTick = 1'b0;

  always @(negedge CLK) begin
    if (out_tick === 1'b1) begin
      obsCh.push_back(int'(out_ch));
      obsY.push_back(longint'(out_sample));
      obsEdge.push_back(edgeCnt);
      if (prevTick) doubleTicks++;
    end
    prevTick = (out_tick === 1'b1);
  end

  int     mCoef[NCH][5];
  longint mX1[NCH], mX2[NCH], mY1[NCH], mY2[NCH];
  int     mLast;
  int     expCh[$];
  longint expY[$];

  int vectors = 0;
  int miscompares = 0;
  int tickEdge = 0;
  int gotEdge[NCH];

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      for (int t = 0; t < 5; t++) mCoef[c][t] = 0;
      mX1[c] = 0; mX2[c] = 0; mY1[c] = 0; mY2[c] = 0;
    end
    mLast = NCH - 1;
  endfunction

  function automatic longint modelStep(input int c, input longint x);
    longint acc;
    longint y;
    logic signed [DW-1:0] wrapped;
    acc = mCoef[c][0] * x + mCoef[c][1] * mX1[c] + mCoef[c][2] * mX2[c]
        + mCoef[c][3] * mY1[c] + mCoef[c][4] * mY2[c];
    y = acc >>> FRAC;
`ifdef IIR_SCHED_SAT_EN
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
`else
    wrapped = y[DW-1:0];
    y = longint'(wrapped);
`endif
    mX2[c] = mX1[c]; mX1[c] = x;
    mY2[c] = mY1[c]; mY1[c] = y;
    return y;
  endfunction

  function automatic void expectService(input logic [NCH-1:0] mask,
                                        input logic [NCH*DW-1:0] samples);
    int start;
    int c;
    logic signed [DW-1:0] s;
    start = mLast;
    for (int i = 1; i <= NCH; i++) begin
      c = (start + i) % NCH;
      if (mask[c]) begin
        s = samples[c*DW +: DW];
        expCh.push_back(c);
        expY.push_back(modelStep(c, longint'(s)));
        mLast = c;
      end
    end
  endfunction

  function automatic logic [NCH*DW-1:0] pack4(input int s0, input int s1,
                                              input int s2, input int s3);
    return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] samples,
                               input logic we, input logic [CHW+2:0] addr,
                               input logic signed [CW-1:0] data);
    @(negedge CLK);
    in_tick   = mask;
    in_sample = samples;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_data  = data;
    if (mask != '0) tickEdge = edgeCnt + 1;
    if (we && addr[2:0] < 3'd5) mCoef[addr[4:3]][addr[2:0]] = int'(data);
    @(negedge CLK);
    in_tick = '0;
    cfg_we  = 1'b0;
  endtask

  task automatic cfgWrite(input int ch, input int tap, input int value);
    applyStimulus('0, '0, 1'b1, {2'(ch), 3'(tap)}, 16'(value));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic doReset(input int n);
    @(negedge CLK);
    RSTb = 1'b0;
    repeat (n) @(negedge CLK);
    RSTb = 1'b1;
    modelReset();
  endtask

  task automatic verifyOutputs(input int n, input int budget);
    for (int i = 0; i < budget && obsCh.size() < n; i++) @(negedge CLK);
    checkOutput("outCount", obsCh.size(), n);
    for (int k = 0; k < n; k++) begin
      if (obsCh.size() > 0 && expCh.size() > 0) begin
        gotEdge[k] = obsEdge.pop_front();
        checkOutput($sformatf("outCh[%0d]", k), obsCh.pop_front(), expCh.pop_front());
        checkOutput($sformatf("outSample[%0d]", k), obsY.pop_front(), expY.pop_front());
      end
    end
  endtask

  initial begin
    logic [NCH-1:0]    mask;
    logic [NCH*DW-1:0] samples;
    logic              we;
    logic [CHW+2:0]    addr;
    logic signed [CW-1:0] data;

    in_tick = '0; in_sample = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    RSTb = 1'b0;
    modelReset();
    repeat (3) @(negedge CLK);
    checkOutput("rstOutSample", out_sample, 0);
    checkOutput("rstOutCh", out_ch, 0);
    checkOutput("rstOutTick", out_tick, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOverrun", overrun, 0);
    RSTb = 1'b1;

    $display("[TB] passthrough");
    cfgWrite(0, 0, 512);
    applyStimulus(4'b0001, pack4(1234, 0, 0, 0), 1'b0, '0, '0);
    expectService(4'b0001, pack4(1234, 0, 0, 0));
    checkOutput("busyIdle", busy, 0);
    @(negedge CLK);
    checkOutput("busyLoad", busy, 1);
    verifyOutputs(1, 30);
    checkOutput("passLatency", gotEdge[0] - tickEdge, 9);

    $display("[TB] recursion");
    cfgWrite(1, 0, 512);
    cfgWrite(1, 3, 256);
    for (int i = 0; i < 4; i++) begin
      samples = pack4(0, (i == 0) ? 512 : 0, 0, 0);
      applyStimulus(4'b0010, samples, 1'b0, '0, '0);
      expectService(4'b0010, samples);
      verifyOutputs(1, 30);
    end

    $display("[TB] saturation");
    cfgWrite(2, 0, 1023);
    applyStimulus(4'b0100, pack4(0, 0, 30000, 0), 1'b0, '0, '0);
    expectService(4'b0100, pack4(0, 0, 30000, 0));
    verifyOutputs(1, 30);

    $display("[TB] arbitration");
    doReset(2);
    for (int c = 0; c < NCH; c++) cfgWrite(c, 0, 512);
    for (int b = 0; b < 2; b++) begin
      samples = pack4(100 + b, -200 - b, 300 + b, -400 - b);
      applyStimulus(4'b1111, samples, 1'b0, '0, '0);
      expectService(4'b1111, samples);
      verifyOutputs(4, 60);
      for (int k = 0; k < NCH; k++)
        checkOutput($sformatf("burstLatency[%0d]", k), gotEdge[k] - tickEdge, 9 * (k + 1));
    end
    checkOutput("noOverrunBurst", overrun, 0);

    $display("[TB] overrun");
    applyStimulus(4'b0001, pack4(11, 0, 0, 0), 1'b0, '0, '0);
    expectService(4'b0001, pack4(11, 0, 0, 0));
    idleCycles(1);
    applyStimulus(4'b1000, pack4(0, 0, 0, 777), 1'b0, '0, '0);
    applyStimulus(4'b1000, pack4(0, 0, 0, -888), 1'b0, '0, '0);
    expectService(4'b1000, pack4(0, 0, 0, -888));
    verifyOutputs(2, 40);
    checkOutput("overrunCh3", overrun, 4'b1000);

    $display("[TB] reset during MAC2");
    applyStimulus(4'b0010, pack4(0, 5000, 0, 0), 1'b0, '0, '0);
    idleCycles(4);
    checkOutput("busyMac2", busy, 1);
    RSTb = 1'b0;
    idleCycles(2);
    checkOutput("abortOutSample", out_sample, 0);
    checkOutput("abortOutCh", out_ch, 0);
    checkOutput("abortOutTick", out_tick, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortOverrun", overrun, 0);
    RSTb = 1'b1;
    modelReset();
    idleCycles(20);
    checkOutput("noTickAfterAbort", obsCh.size(), 0);

    $display("[TB] cfg write during MAC");
    cfgWrite(0, 0, 512);
    applyStimulus(4'b0001, pack4(1000, 0, 0, 0), 1'b0, '0, '0);
    expectService(4'b0001, pack4(1000, 0, 0, 0));
    idleCycles(1);
    cfgWrite(0, 0, 1024);
    verifyOutputs(1, 30);
    applyStimulus(4'b0001, pack4(1000, 0, 0, 0), 1'b0, '0, '0);
    expectService(4'b0001, pack4(1000, 0, 0, 0));
    verifyOutputs(1, 30);

    $display("[TB] random bursts");
    for (int it = 0; it < 40; it++) begin
      mask    = 4'($urandom_range(1, 15));
      samples = {$urandom, $urandom};
      we      = 1'($urandom_range(0, 1));
      addr    = 5'($urandom);
      data    = 16'($urandom);
      applyStimulus(mask, samples, we, addr, data);
      expectService(mask, samples);
      verifyOutputs($countones(mask), 60);
    end

    checkOutput("outTickGap", doubleTicks, 0);
    checkOutput("finalOverrun", overrun, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
